// File: rtl/rtc_xfer_pkg.sv
// Shared types and default phase timings for the RTC multiplexed-bus transfer controller.
package rtc_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    GAP,
    DATA_STROBE,
    DATA_HOLD,
    RECOVER
  } state_t;

  localparam int unsigned T_ADS_DEF = 2;
  localparam int unsigned T_CS_DEF  = 6;
  localparam int unsigned T_AH_DEF  = 3;
  localparam int unsigned T_W_DEF   = 10;
  localparam int unsigned T_DH_DEF  = 2;
  localparam int unsigned T_REC_DEF = 6;

  // IDLE has no timed length; 1 keeps the timer at zero after the final RECOVER.
  function automatic int unsigned phase_len(input state_t s,
                                            input int unsigned t_ads,
                                            input int unsigned t_cs,
                                            input int unsigned t_ah,
                                            input int unsigned t_w,
                                            input int unsigned t_dh,
                                            input int unsigned t_rec);
    int unsigned len;
    case (s)
      ADDR_SETUP:  len = t_ads;
      ADDR_STROBE: len = t_cs;
      ADDR_HOLD:   len = t_ah;
      GAP:         len = t_w;
      DATA_STROBE: len = t_cs;
      DATA_HOLD:   len = t_dh;
      RECOVER:     len = t_rec;
      default:     len = 1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rtc_bus_xfer_ctrl_timer.sv
// Loadable down-counter timing one bus phase; o_last marks the phase's final cycle.
module rtc_phase_timer
  import rtc_xfer_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_last,
  output logic             o_last_next
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len - CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == '0);
  // Lets the controller register pulses that must land on a phase's final cycle.
  assign o_last_next = i_load ? (i_len == CNT_W'(1)) : (r_cnt == CNT_W'(1));

endmodule

// File: rtl/rtc_bus_xfer_ctrl.sv
// Multiplexed AD-bus transfer controller for V3023-class RTC chips.
// Define RTC_XFER_BURST_EN to enable auto-incrementing multi-register bursts.
module rtc_bus_xfer_ctrl
  import rtc_xfer_pkg::*;
#(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int CNT_W     = 6,
  parameter int T_ADS     = T_ADS_DEF,
  parameter int T_CS      = T_CS_DEF,
  parameter int T_AH      = T_AH_DEF,
  parameter int T_W       = T_W_DEF,
  parameter int T_DH      = T_DH_DEF,
  parameter int T_REC     = T_REC_DEF,
  parameter int MAX_BURST = 8,
  parameter int BL_W      = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_read,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [BL_W-1:0] i_burst_len,
  input  logic [DW-1:0]   i_wr_data,
  output logic            o_wr_take,
  output logic [DW-1:0]   o_rdata,
  output logic            o_rdata_valid,
  output logic            o_busy,
  output logic            o_done,
  output logic [DW-1:0]   o_ad_out,
  output logic            o_ad_oe,
  input  logic [DW-1:0]   i_ad_in,
  output logic            o_ad_n,
  output logic            o_cs_n,
  output logic            o_rd_n,
  output logic            o_wr_n
);

  if (T_ADS == 0 || T_CS == 0 || T_AH == 0 || T_W == 0 || T_DH == 0 || T_REC == 0) begin : g_bad_timing
    $error("rtc_bus_xfer_ctrl: every phase timing must be at least one cycle");
  end
  if (AW > DW) begin : g_bad_width
    $error("rtc_bus_xfer_ctrl: address width must not exceed bus width");
  end

  state_t           r_state, w_state_next;
  logic             r_read, w_read_next;
  logic [AW-1:0]    r_addr, w_addr_next;
  logic [DW-1:0]    r_wdata, w_wdata_next;
  logic             w_accept, w_load, w_last, w_last_next;
  logic             w_more, w_more_next, w_done_next;
  logic [CNT_W-1:0] w_len;

`ifdef RTC_XFER_BURST_EN
  logic [BL_W-1:0] r_beats, w_beats_next;
  assign w_more      = (r_beats != '0);
  assign w_more_next = (w_beats_next != '0);
`else
  logic w_unused_burst_len;
  assign w_unused_burst_len = ^i_burst_len;
  assign w_more      = 1'b0;
  assign w_more_next = 1'b0;
`endif

  assign w_accept    = i_req_valid && o_req_ready;
  assign w_load      = (r_state == IDLE) ? w_accept : w_last;
  assign w_len       = CNT_W'(phase_len(w_state_next, T_ADS, T_CS, T_AH, T_W, T_DH, T_REC));
  assign w_done_next = (w_state_next == RECOVER) && w_last_next && !w_more_next;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_len      (w_len),
    .o_last     (w_last),
    .o_last_next(w_last_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_read_next  = r_read;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
`ifdef RTC_XFER_BURST_EN
    w_beats_next = r_beats;
`endif
    if (r_state == IDLE) begin
      if (w_accept) begin
        w_state_next = ADDR_SETUP;
        w_read_next  = i_req_read;
        w_addr_next  = i_req_addr;
`ifdef RTC_XFER_BURST_EN
        if (int'(i_burst_len) > MAX_BURST - 1) w_beats_next = BL_W'(MAX_BURST - 1);
        else                                   w_beats_next = i_burst_len;
`endif
      end
    end else if (w_last) begin
      case (r_state)
        ADDR_SETUP:  w_state_next = ADDR_STROBE;
        ADDR_STROBE: w_state_next = ADDR_HOLD;
        ADDR_HOLD:   w_state_next = GAP;
        GAP: begin
          w_state_next = DATA_STROBE;
          if (!r_read) w_wdata_next = i_wr_data;
        end
        DATA_STROBE: w_state_next = DATA_HOLD;
        DATA_HOLD:   w_state_next = RECOVER;
        RECOVER: begin
          if (w_more) begin
            w_state_next = ADDR_SETUP;
            w_addr_next  = r_addr + AW'(1);
`ifdef RTC_XFER_BURST_EN
            w_beats_next = r_beats - BL_W'(1);
`endif
          end else begin
            w_state_next = IDLE;
          end
        end
        default:     w_state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_read        <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
`ifdef RTC_XFER_BURST_EN
      r_beats       <= '0;
`endif
      o_req_ready   <= 1'b1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_wr_take     <= 1'b0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_ad_out      <= '0;
      o_ad_oe       <= 1'b0;
      o_ad_n        <= 1'b1;
      o_cs_n        <= 1'b1;
      o_rd_n        <= 1'b1;
      o_wr_n        <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_read        <= w_read_next;
      r_addr        <= w_addr_next;
      r_wdata       <= w_wdata_next;
`ifdef RTC_XFER_BURST_EN
      r_beats       <= w_beats_next;
`endif
      o_req_ready   <= (w_state_next == IDLE);
      o_busy        <= (w_state_next != IDLE);
      o_done        <= 1'b0;
      o_wr_take     <= 1'b0;
      o_rdata_valid <= 1'b0;
      o_ad_out      <= '0;
      o_ad_oe       <= 1'b0;
      o_ad_n        <= 1'b1;
      o_cs_n        <= 1'b1;
      o_rd_n        <= 1'b1;
      o_wr_n        <= 1'b1;
      case (w_state_next)
        ADDR_SETUP, ADDR_HOLD: begin
          o_ad_n   <= 1'b0;
          o_ad_oe  <= 1'b1;
          o_ad_out <= DW'(w_addr_next);
        end
        ADDR_STROBE: begin
          o_ad_n   <= 1'b0;
          o_ad_oe  <= 1'b1;
          o_ad_out <= DW'(w_addr_next);
          o_cs_n   <= 1'b0;
          o_wr_n   <= 1'b0;
        end
        GAP:       o_wr_take <= !w_read_next && w_last_next;
        DATA_STROBE: begin
          o_cs_n <= 1'b0;
          if (w_read_next) begin
            o_rd_n <= 1'b0;
          end else begin
            o_wr_n   <= 1'b0;
            o_ad_oe  <= 1'b1;
            o_ad_out <= w_wdata_next;
          end
        end
        DATA_HOLD: begin
          if (w_read_next) begin
            o_rdata_valid <= (r_state == DATA_STROBE);
          end else begin
            o_ad_oe  <= 1'b1;
            o_ad_out <= w_wdata_next;
          end
        end
        RECOVER:   o_done <= w_done_next;
        default:   o_done <= 1'b0;
      endcase
      if (r_state == DATA_STROBE && r_read && w_last) o_rdata <= i_ad_in;
    end
  end

endmodule
